nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle wide-operand adder built around one 4-bit ripple_adder instance.
//  Latches WIDTH-bit operands via a valid/ready handshake and feeds them to ripple_adder one nibble per clock, LSB first.
//  Registers each 4-bit sum and chains c4 back as the next nibble's carry-in.
//  Sits directly upstream/downstream of ripple_adder: drives its a/b/c inputs and consumes its s_out/c4.
// PARAMETERS
//  WIDTH    16           operand/sum width; multiple of 4, >= 4; otherwise elaboration error
//  NIBBLES  WIDTH/4      derived localparam; RUN cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand request
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A; sampled on accept
//  b          in   WIDTH  operand B; sampled on accept
//  cin        in   1      carry-in; sampled on accept
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow; present only with OVERFLOW_EN
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//    All operand, carry and counter registers are cleared.
//  - FSM has three states: IDLE, RUN, DONE.
//  - IDLE: in_ready=1.
//    On in_valid&in_ready at an edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, goto RUN.
//  - RUN: in_ready=0, out_valid=0.
//    Drive ripple_adder with (a_sh[3:0], b_sh[3:0], carry).
//    At each edge:
//      a_sh>>=4, b_sh>>=4;
//      res<={s_out,res[WIDTH-1:4]} (the new nibble enters from the MSB side);
//      carry<=c4; cnt++.
//    When cnt==NIBBLES-1 at an edge, goto DONE.
//  - DONE: out_valid=1; sum=res, cout=carry.
//    sum and cout are held stable while out_ready=0.
//    On out_ready=1 at an edge, goto IDLE.
//  - Latency: accept at edge k -> out_valid=1 after edge k+NIBBLES.
//    WIDTH=4 -> 1 RUN cycle.
//  - Throughput: one operation per NIBBLES+2 cycles (the DONE->IDLE step costs one bubble).
//  - in_valid is ignored outside IDLE. a, b and cin need only be stable at the accept edge.
//  - out_ready is ignored outside DONE.
//  - sum and cout are registered; there is no combinational path from inputs to outputs.
//  - sum and cout update only on entry to DONE, and keep their last value in IDLE/RUN.
//  - Wrap-around: sum is modulo 2^WIDTH; the lost carry appears only on cout.
//  - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
//  - cnt is a ceil(log2(NIBBLES))-bit counter (min 1 bit).
// CONFIGURATION
//  OVERFLOW_EN defined:
//    port ovf exists.
//    In DONE, ovf = (a_msb==b_msb) && (res[WIDTH-1]!=a_msb).
//    a_msb and b_msb are captured at accept.
//    ovf is registered with sum and reset to 0.
//  OVERFLOW_EN undefined:
//    no ovf port; no a_msb/b_msb registers.
//    All other behaviour is identical.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x4321, cin=0 accepted at edge k:
//     out_valid=1 after edge k+4; sum=0x5555, cout=0.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 nibbles).
//  3. a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0.
//     Back-to-back request: in_ready=0 until the cycle after the result is taken.
//  4. Backpressure: hold out_ready=0 for 3 cycles in DONE.
//     sum and cout stay stable, in_ready=0; on out_ready=1 -> IDLE, in_ready=1.
//  5. Assert rst 2 cycles into RUN:
//     out_valid=0, in_ready=1, sum=0 immediately.
//     The next op 0x0001+0x0001 returns 0x0002.
//  6. OVERFLOW_EN:
//     0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
//     0xFFFF+0xFFFF -> sum=0xFFFE, ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple_adder, one nibble per clock, LSB first.
// Optional macro OVERFLOW_EN adds the signed-overflow output ovf.
// Ports: clk, rst (async, active-high), in_valid/in_ready + a, b, cin (operand handshake),
//        out_valid/out_ready + sum, cout (result handshake), ovf (only with OVERFLOW_EN).

module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s_out,
  output logic       c4
);
  logic [4:0] cy;

  assign cy[0] = c;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_out[i] = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign c4 = cy[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       s_out;
  logic             c4;

`ifdef OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  ripple_adder u_ra (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .c     (carry),
    .s_out (s_out),
    .c4    (c4)
  );

  // New nibble enters at the MSB end; after NIBBLES shifts
  // the first nibble has walked down to bits [3:0].
  if (WIDTH == 4) begin : g_one
    assign res_nx = s_out;
  end else begin : g_many
    assign res_nx = {s_out, res[WIDTH-1:4]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef OVERFLOW_EN
      ovf       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef OVERFLOW_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          res   <= res_nx;
          carry <= c4;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= res_nx;
            cout      <= c4;
`ifdef OVERFLOW_EN
            ovf       <= (a_msb == b_msb) &&
                         (res_nx[WIDTH-1] != a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
